// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet locking that shares one UART transmitter among
// NUM_REQ byte producers; ownership ends on last byte, burst limit or hold timeout.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned HOLD_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [NUM_REQ-1:0]   grant
);

  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned HOLD_W  = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam int unsigned BURST_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE,
    HOLD
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 last_q, last_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 tx_start_q, tx_start_d;
  logic [7:0]           tx_data_q, tx_data_d;

  logic [7:0]           req_byte [NUM_REQ];
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     cand;
  logic                 load_now;
  logic [IDX_W-1:0]     load_idx;
  logic [BURST_W-1:0]   burst_base;

  // Unpack the flattened byte bus into one byte per requester.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_byte[i] = req_data[8*i +: 8];
    end
  end

  // First valid requester after the last winner, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
      burst_q     <= '0;
      hold_q      <= '0;
      last_q      <= 1'b0;
      req_ready_q <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_q     <= burst_d;
      hold_q      <= hold_d;
      last_q      <= last_d;
      req_ready_q <= req_ready_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
    end
  end

  // Next state; the LOAD-cycle outputs are prepared on every transition into LOAD
  // so that tx_start/req_ready are registered and high exactly while in LOAD.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_d     = burst_q;
    hold_d      = hold_q;
    last_d      = last_q;
    req_ready_d = '0;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    load_now    = 1'b0;
    load_idx    = owner_q;
    burst_base  = burst_q;

    case (state_q)
      IDLE: begin
        if (win_found && !tx_busy) begin
          state_d          = LOAD;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
          rr_ptr_d         = win_idx;
          burst_base       = '0;
          load_now         = 1'b1;
          load_idx         = win_idx;
        end
      end
      LOAD: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q || (burst_q >= BURST_W'(MAX_BURST))) begin
            state_d = IDLE;
            grant_d = '0;
          end else if (req_valid[owner_q]) begin
            state_d  = LOAD;
            load_now = 1'b1;
          end else begin
            state_d = HOLD;
            hold_d  = '0;
          end
        end
      end
      HOLD: begin
        if (req_valid[owner_q]) begin
          state_d  = LOAD;
          load_now = 1'b1;
        end else if (hold_q == HOLD_W'(HOLD_TIMEOUT - 1)) begin
          // Owner stalled too long: release the transmitter, nothing was accepted.
          state_d = IDLE;
          grant_d = '0;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    if (load_now) begin
      tx_start_d            = 1'b1;
      tx_data_d             = req_byte[load_idx];
      req_ready_d[load_idx] = 1'b1;
      burst_d               = burst_base + BURST_W'(1);
      last_d                = req_last[load_idx];
    end
  end

  assign req_ready = req_ready_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-based producers, a simple transmitter
// model and a log of every started byte checked against hand-computed sequences.
module tb_uart_tx_arbiter;

  localparam int unsigned NR    = 4;
  localparam int unsigned FRAME = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy = 1'b0;
  logic [NR-1:0]   grant;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .MAX_BURST    (4),
    .HOLD_TIMEOUT (8)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant     (grant)
  );

  // Producer queues: pushed by the stimulus, popped on req_ready.
  logic [7:0]  q_data [NR][64];
  logic        q_last [NR][64];
  logic [5:0]  wr_ptr [NR] = '{default: '0};
  logic [5:0]  rd_ptr [NR] = '{default: '0};

  int unsigned bcnt      = 0;
  int unsigned ready_bad = 0;
  int unsigned log_n     = 0;
  logic [3:0]  log_g [128];
  logic [7:0]  log_d [128];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned base     = 0;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_valid[i]      = (rd_ptr[i] != wr_ptr[i]);
      req_data[8*i +: 8] = q_data[i][rd_ptr[i]];
      req_last[i]       = q_last[i][rd_ptr[i]];
    end
  end

  // Transmitter model, byte log and handshake monitor.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) rd_ptr[i] = wr_ptr[i];
      tx_busy = 1'b0;
      bcnt    = 0;
    end else begin
      if (req_ready != (tx_start ? grant : 4'b0000)) ready_bad++;
      if (tx_start) begin
        if (log_n < 128) begin
          log_g[log_n[6:0]] = grant;
          log_d[log_n[6:0]] = tx_data;
        end
        log_n++;
        tx_busy = 1'b1;
        bcnt    = FRAME;
      end else if (bcnt != 0) begin
        bcnt--;
        if (bcnt == 0) tx_busy = 1'b0;
      end
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i]) rd_ptr[i] = rd_ptr[i] + 6'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    q_data[r][wr_ptr[r]] = d;
    q_last[r][wr_ptr[r]] = l;
    wr_ptr[r] = wr_ptr[r] + 6'd1;
  endtask

  function automatic logic idle_now();
    logic empty;
    empty = 1'b1;
    for (int i = 0; i < NR; i++) if (rd_ptr[i] != wr_ptr[i]) empty = 1'b0;
    return empty && (grant == 4'b0000) && !tx_busy;
  endfunction

  task automatic drain(input string tag);
    int c;
    c = 0;
    while (c < 2000 && !idle_now()) begin
      tick();
      c++;
    end
    check({tag, "_drain"}, 32'(idle_now()), 32'd1);
  endtask

  task automatic expect_tx(input string tag, input int k, input logic [3:0] g, input logic [7:0] d);
    check(tag, {20'd0, log_g[7'(base + k)], log_d[7'(base + k)]}, {20'd0, g, d});
  endtask

  task automatic wait_busy(input string tag, input logic lvl);
    int c;
    c = 0;
    while (c < 100 && tx_busy != lvl) begin
      tick();
      c++;
    end
    check(tag, 32'(tx_busy), 32'(lvl));
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    rst = 1'b0;

    // Round-robin from reset: 0,1,2,0 then req3 ahead of req0.
    push(0, 8'h10, 1'b1); push(0, 8'h11, 1'b1);
    push(1, 8'h20, 1'b1); push(2, 8'h30, 1'b1);
    base = log_n;
    drain("t3a");
    check("t3a_cnt", log_n - base, 32'd4);
    expect_tx("t3a_0", 0, 4'b0001, 8'h10);
    expect_tx("t3a_1", 1, 4'b0010, 8'h20);
    expect_tx("t3a_2", 2, 4'b0100, 8'h30);
    expect_tx("t3a_3", 3, 4'b0001, 8'h11);
    push(0, 8'h12, 1'b1); push(3, 8'h40, 1'b1);
    base = log_n;
    drain("t3b");
    check("t3b_cnt", log_n - base, 32'd2);
    expect_tx("t3b_0", 0, 4'b1000, 8'h40);
    expect_tx("t3b_1", 1, 4'b0001, 8'h12);

    // Single three-byte packet.
    push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
    base = log_n;
    drain("t2");
    check("t2_cnt", log_n - base, 32'd3);
    expect_tx("t2_0", 0, 4'b0001, 8'h41);
    expect_tx("t2_1", 1, 4'b0001, 8'h42);
    expect_tx("t2_2", 2, 4'b0001, 8'h43);

    // Locking: req2 waits while req1 is mid-packet.
    push(1, 8'h51, 1'b0); push(1, 8'h52, 1'b0); push(1, 8'h53, 1'b1);
    base = log_n;
    repeat (2) tick();
    push(2, 8'h61, 1'b1);
    repeat (3) tick();
    check("t4_grant_mid", 32'(grant), 32'h2);
    check("t4_req2_held", 32'(rd_ptr[2] != wr_ptr[2]), 32'd1);
    drain("t4");
    check("t4_cnt", log_n - base, 32'd4);
    expect_tx("t4_0", 0, 4'b0010, 8'h51);
    expect_tx("t4_1", 1, 4'b0010, 8'h52);
    expect_tx("t4_2", 2, 4'b0010, 8'h53);
    expect_tx("t4_3", 3, 4'b0100, 8'h61);

    // Burst limit of 4: req0 rotates out, req1 served, req0 resumes at byte 5.
    for (int k = 0; k < 10; k++) push(0, 8'hA0 + 8'(k), 1'b0);
    push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b1);
    base = log_n;
    drain("t5");
    check("t5_cnt", log_n - base, 32'd12);
    for (int k = 0; k < 4; k++) expect_tx($sformatf("t5_a%0d", k), k, 4'b0001, 8'hA0 + 8'(k));
    expect_tx("t5_b0", 4, 4'b0010, 8'hB0);
    expect_tx("t5_b1", 5, 4'b0010, 8'hB1);
    for (int k = 4; k < 10; k++) expect_tx($sformatf("t5_a%0d", k), k + 2, 4'b0001, 8'hA0 + 8'(k));

    // Hold timeout: req2 stalls after one byte, req3 waiting.
    push(2, 8'hC0, 1'b0); push(3, 8'hD0, 1'b1);
    base = log_n;
    wait_busy("t6_busy_hi", 1'b1);
    wait_busy("t6_busy_lo", 1'b0);
    repeat (7) tick();
    check("t6_hold7", 32'(grant), 32'h4);
    tick();
    check("t6_drop", 32'(grant), 32'h0);
    tick();
    check("t6_req3", 32'(grant), 32'h8);
    drain("t6");
    check("t6_cnt", log_n - base, 32'd2);
    expect_tx("t6_0", 0, 4'b0100, 8'hC0);
    expect_tx("t6_1", 1, 4'b1000, 8'hD0);

    // Asynchronous reset while req1 waits for its frame to finish.
    push(1, 8'hE0, 1'b0); push(1, 8'hE1, 1'b1);
    wait_busy("t1_busy_hi", 1'b1);
    repeat (2) tick();
    check("t1_pre_grant", 32'(grant), 32'h2);
    rst = 1'b1;
    #1;
    check("t1_grant", 32'(grant), 32'h0);
    check("t1_start", 32'(tx_start), 32'd0);
    check("t1_ready", 32'(req_ready), 32'd0);
    check("t1_data", 32'(tx_data), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    push(1, 8'hF1, 1'b1); push(0, 8'hF0, 1'b1);
    base = log_n;
    drain("t1");
    check("t1_cnt", log_n - base, 32'd2);
    expect_tx("t1_0", 0, 4'b0001, 8'hF0);
    expect_tx("t1_1", 1, 4'b0010, 8'hF1);

    check("ready_protocol", ready_bad, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
